tnn_cmp_sched: RTL and testbench

//  Time-multiplexes one combinational 3-bit approximate TNN comparator core (a, b, c -> 1 bit)

---
 rtl/tnn_cmp_sched.sv | 174 +++++++++++++++++
 tb/tb_tnn_cmp_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tnn_cmp_sched.sv
// Shares one combinational 3-bit TNN comparator core across NEURONS evaluations per job.
// Only mask-enabled neurons consume a cycle; results return through a valid/ready handshake.
module tnn_cmp_sched #(
  parameter int NEURONS = 8,
  parameter int W       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [NEURONS*W-1:0] job_a,
  input  logic [NEURONS*W-1:0] job_b,
  input  logic [NEURONS*W-1:0] job_c,
  input  logic [NEURONS-1:0]   job_mask,
  output logic [W-1:0]         cmp_a,
  output logic [W-1:0]         cmp_b,
  output logic [W-1:0]         cmp_c,
  input  logic                 cmp_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NEURONS-1:0]   res_bits,
  output logic                 busy
);

  localparam int IW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NEURONS*W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [NEURONS-1:0]   mask_q, mask_d;
  logic [W-1:0]         cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d, cmp_c_q, cmp_c_d;
  logic [NEURONS-1:0]   res_bits_q, res_bits_d;
  logic                 start_ready_q, start_ready_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;
  logic [IW:0]          first_s, next_s;

  // {found, index} of the lowest set bit of m
  function automatic logic [IW:0] first_set(input logic [NEURONS-1:0] m);
    logic [IW:0] r;
    r = '0;
    for (int i = NEURONS-1; i >= 0; i--) begin
      r = m[i] ? {1'b1, IW'(i)} : r;
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit of m strictly above cur
  function automatic logic [IW:0] next_set(input logic [NEURONS-1:0] m,
                                           input logic [IW-1:0]    cur);
    logic [IW:0] r;
    r = '0;
    for (int i = NEURONS-1; i >= 0; i--) begin
      r = (m[i] && (i > int'(cur))) ? {1'b1, IW'(i)} : r;
    end
    return r;
  endfunction

  assign first_s = first_set(job_mask);
  assign next_s  = next_set(mask_q, idx_q);

  // Next-state logic; an empty mask still spends one RUN cycle so latency is max(P,1)
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_valid ? S_RUN : S_IDLE;
      S_RUN:   state_d = next_s[IW] ? S_RUN : S_DONE;
      S_DONE:  state_d = res_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    mask_d     = mask_q;
    cmp_a_d    = cmp_a_q;
    cmp_b_d    = cmp_b_q;
    cmp_c_d    = cmp_c_q;
    res_bits_d = res_bits_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d        = job_a;
          b_d        = job_b;
          c_d        = job_c;
          mask_d     = job_mask;
          res_bits_d = '0;
          idx_d      = first_s[IW] ? first_s[IW-1:0] : '0;
          if (first_s[IW]) begin
            cmp_a_d = job_a[first_s[IW-1:0]*W +: W];
            cmp_b_d = job_b[first_s[IW-1:0]*W +: W];
            cmp_c_d = job_c[first_s[IW-1:0]*W +: W];
          end else begin
            cmp_a_d = cmp_a_q;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_RUN: begin
        if (mask_q[idx_q]) begin
          res_bits_d[idx_q] = cmp_out;
        end else begin
          res_bits_d = res_bits_q;
        end
        if (next_s[IW]) begin
          idx_d   = next_s[IW-1:0];
          cmp_a_d = a_q[next_s[IW-1:0]*W +: W];
          cmp_b_d = b_q[next_s[IW-1:0]*W +: W];
          cmp_c_d = c_q[next_s[IW-1:0]*W +: W];
        end else begin
          idx_d = idx_q;
        end
      end
      S_DONE:  idx_d = idx_q;
      default: idx_d = '0;
    endcase
    start_ready_d = (state_d == S_IDLE);
    res_valid_d   = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      mask_q        <= '0;
      cmp_a_q       <= '0;
      cmp_b_q       <= '0;
      cmp_c_q       <= '0;
      res_bits_q    <= '0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      mask_q        <= mask_d;
      cmp_a_q       <= cmp_a_d;
      cmp_b_q       <= cmp_b_d;
      cmp_c_q       <= cmp_c_d;
      res_bits_q    <= res_bits_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign res_bits    = res_bits_q;
  assign busy        = busy_q;
  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;
  assign cmp_c       = cmp_c_q;

endmodule

// File: tb/tb_tnn_cmp_sched.sv
// Scoreboard bench for tnn_cmp_sched; a behavioural comparator core is driven from cmp_a/b/c.
module tb_tnn_cmp_sched;
  localparam int N = 8;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [N*W-1:0] job_a, job_b, job_c;
  logic [N-1:0]   job_mask;
  logic [W-1:0]   cmp_a, cmp_b, cmp_c;
  logic           cmp_out;
  logic           res_valid;
  logic           res_ready;
  logic [N-1:0]   res_bits;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] exp_bits_q[$];
  int           exp_lat_q[$];

  tnn_cmp_sched #(.NEURONS(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_mask(job_mask),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_c(cmp_c), .cmp_out(cmp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_bits(res_bits), .busy(busy)
  );

  always #5 clk = ~clk;

  // Approximate comparator: b above the mean of a and c
  function automatic logic core_fn(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, c};
    return ({1'b0, b} > (s >> 1));
  endfunction

  assign cmp_out = core_fn(cmp_a, cmp_b, cmp_c);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic [N*W-1:0] c, input logic [N-1:0] m, input int hold);
    logic [N-1:0]   eb;
    logic [3*W-1:0] trip[$];
    logic [3*W-1:0] exp_cmp;
    logic [N-1:0]   got_bits;
    int p, cyc, k;
    eb = '0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        eb[i] = core_fn(a[i*W +: W], b[i*W +: W], c[i*W +: W]);
        trip.push_back({a[i*W +: W], b[i*W +: W], c[i*W +: W]});
      end
    end
    p = trip.size();
    exp_bits_q.push_back(eb);
    exp_lat_q.push_back((p > 0) ? p : 1);
    exp_cmp = {cmp_a, cmp_b, cmp_c};
    check_eq("start_ready_idle", 32'(start_ready), 32'd1);
    job_a = a; job_b = b; job_c = c; job_mask = m;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    job_a = 24'($urandom); job_b = 24'($urandom); job_c = 24'($urandom);
    job_mask = 8'($urandom);
    k = 0;
    if (p > 0) exp_cmp = trip[0];
    check_eq("busy_accept", 32'(busy), 32'd1);
    check_eq("start_ready_busy", 32'(start_ready), 32'd0);
    check_eq("cmp_accept", 32'({cmp_a, cmp_b, cmp_c}), 32'(exp_cmp));
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!res_valid) begin
        k++;
        if (k < p) exp_cmp = trip[k];
      end
      check_eq("cmp_run", 32'({cmp_a, cmp_b, cmp_c}), 32'(exp_cmp));
    end
    check_eq("latency", 32'(cyc), 32'(exp_lat_q.pop_front()));
    got_bits = res_bits;
    check_eq("res_bits", 32'(res_bits), 32'(exp_bits_q.pop_front()));
    // Consumer stalls while a new request is offered and must be ignored
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      job_mask = 8'($urandom);
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(res_valid), 32'd1);
      check_eq("hold_bits", 32'(res_bits), 32'(got_bits));
      check_eq("hold_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_eq("post_valid", 32'(res_valid), 32'd0);
    check_eq("post_start_ready", 32'(start_ready), 32'd1);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_bits", 32'(res_bits), 32'(got_bits));
    check_eq("post_cmp", 32'({cmp_a, cmp_b, cmp_c}), 32'(exp_cmp));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_res_bits"}, 32'(res_bits), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_cmp"}, 32'({cmp_a, cmp_b, cmp_c}), 32'd0);
  endtask

  initial begin
    logic [N*W-1:0] va, vb, vc;
    logic [N-1:0]   m;
    int r;
    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    job_a = '0; job_b = '0; job_c = '0; job_mask = '0;
    #12;
    check_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_job('0, {N{3'd7}}, '0, 8'hFF, 0);
    run_job({N{3'd7}}, '0, {N{3'd7}}, 8'hFF, 1);
    va = 24'($urandom); vb = 24'($urandom); vc = 24'($urandom);
    va[2:0] = 3'd0; vb[2:0] = 3'd7; vc[2:0] = 3'd0;
    va[23:21] = 3'd7; vb[23:21] = 3'd0; vc[23:21] = 3'd7;
    run_job(va, vb, vc, 8'h81, 2);
    run_job(24'($urandom), 24'($urandom), 24'($urandom), 8'h00, 0);
    run_job(24'($urandom), 24'($urandom), 24'($urandom), 8'h3C, 5);

    // Reset while the fourth neuron is on the core
    job_a = '0; job_b = {N{3'd7}}; job_c = '0; job_mask = 8'hFF;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrun_busy", 32'(busy), 32'd1);
    check_eq("midrun_cmp", 32'({cmp_a, cmp_b, cmp_c}), 32'({3'd0, 3'd7, 3'd0}));
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job({N{3'd7}}, '0, {N{3'd7}}, 8'h5A, 1);

    for (int t = 0; t < 1000; t++) begin
      r = $urandom_range(0, 9);
      m = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      run_job(24'($urandom), 24'($urandom), 24'($urandom), m, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
